axi4_slave_mem: RTL and testbench



---
 rtl/axi4_pkg.sv | 22 ++
 rtl/axi4_slave_mem_if.sv | 48 ++++
 rtl/axi4_burst_addr_gen.sv | 111 +++++++++++
 rtl/axi4_slave_mem.sv | 135 +++++++++++++
 tb/tb_axi4_slave_mem.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared types and defaults for the AXI4 slave memory: burst encoding,
// response codes and channel FSM states.
package axi4_pkg;

    localparam int AXI_ADDR_W    = 32;
    localparam int AXI_DATA_W    = 32;
    localparam int AXI_MEM_DEPTH = 1024;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_e;

endpackage

// File: rtl/axi4_slave_mem_if.sv
// AXI4 signal bundle between a master and the slave memory.
interface axi4_slave_mem_if import axi4_pkg::*; #(
    parameter int ADDR_WIDTH = AXI_ADDR_W,
    parameter int DATA_WIDTH = AXI_DATA_W
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [7:0]              AWLEN;
    logic [2:0]              AWSIZE;
    logic [1:0]              AWBURST;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WLAST;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic [7:0]              ARLEN;
    logic [2:0]              ARSIZE;
    logic [1:0]              ARBURST;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic [1:0]              RRESP;
    logic                    RLAST;
    logic                    RVALID;
    logic                    RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output WDATA, WSTRB, WLAST, WVALID, BREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID,
        input  ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  WDATA, WSTRB, WLAST, WVALID, BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID,
        output ARREADY, RDATA, RRESP, RLAST, RVALID
    );

endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Burst address sequencer: tracks beat address/count and flags errors.
// WRAP stepping is only built when AXI4_SLV_MEM_WRAP_EN is defined.
module axi4_burst_addr_gen import axi4_pkg::*; #(
    parameter int ADDR_WIDTH = AXI_ADDR_W,
    parameter int DATA_WIDTH = AXI_DATA_W,
    parameter int MEM_DEPTH  = AXI_MEM_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  adv,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [7:0]            len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] nxt_addr,
    output logic                  nxt_last,
    output logic                  nxt_err
);
    localparam int OFF = $clog2(DATA_WIDTH/8);

    logic [ADDR_WIDTH-1:0] addr_q, step_addr, inc_addr;
    logic [7:0]            cnt_q, len_q, nxt_cnt, nxt_len;
    logic [2:0]            size_q, nxt_size;
    burst_e                burst_q, nxt_burst;
    logic                  serr_q, nxt_serr, start_serr;

    function automatic logic oob(input logic [ADDR_WIDTH-1:0] a);
        return (a >> OFF) >= ADDR_WIDTH'(MEM_DEPTH);
    endfunction

    assign inc_addr = addr_q + (ADDR_WIDTH'(1) << size_q);

`ifdef AXI4_SLV_MEM_WRAP_EN
    logic [ADDR_WIDTH-1:0] wrap_cont, wrap_base;
    assign wrap_cont = ADDR_WIDTH'({1'b0, len_q} + 9'd1) << size_q;
    assign wrap_base = addr_q & ~(wrap_cont - ADDR_WIDTH'(1));
`endif

    // Burst-wide errors are decided once, from the request itself
    always_comb begin
        start_serr = (burst == BURST_RSVD) || (int'(size) > OFF);
`ifdef AXI4_SLV_MEM_WRAP_EN
        if (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))
            start_serr = 1'b1;
`else
        if (burst == BURST_WRAP)
            start_serr = 1'b1;
`endif
    end

    always_comb begin
        step_addr = addr_q;
        case (burst_q)
            BURST_INCR: step_addr = inc_addr;
`ifdef AXI4_SLV_MEM_WRAP_EN
            BURST_WRAP: step_addr = (inc_addr >= wrap_base + wrap_cont) ? wrap_base : inc_addr;
`endif
            default:    step_addr = addr_q;
        endcase
    end

    // nxt_* is the beat that becomes current after this edge
    always_comb begin
        nxt_addr  = addr_q;
        nxt_cnt   = cnt_q;
        nxt_len   = len_q;
        nxt_size  = size_q;
        nxt_burst = burst_q;
        nxt_serr  = serr_q;
        if (load) begin
            nxt_addr  = start_addr;
            nxt_cnt   = 8'd0;
            nxt_len   = len;
            nxt_size  = size;
            nxt_burst = burst_e'(burst);
            nxt_serr  = start_serr;
        end else if (adv) begin
            nxt_addr = step_addr;
            nxt_cnt  = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= BURST_FIXED;
            serr_q  <= 1'b0;
        end else begin
            addr_q  <= nxt_addr;
            cnt_q   <= nxt_cnt;
            len_q   <= nxt_len;
            size_q  <= nxt_size;
            burst_q <= nxt_burst;
            serr_q  <= nxt_serr;
        end
    end

    assign nxt_last = (nxt_cnt == nxt_len);
    assign nxt_err  = nxt_serr | oob(nxt_addr);
    assign addr     = addr_q;
    assign last     = (cnt_q == len_q);
    assign err      = serr_q | oob(addr_q);

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory with independent write/read burst FSMs and byte-strobe
// writes. WRAP support follows AXI4_SLV_MEM_WRAP_EN (see axi4_burst_addr_gen).
module axi4_slave_mem import axi4_pkg::*; #(
    parameter int ADDR_WIDTH = AXI_ADDR_W,
    parameter int DATA_WIDTH = AXI_DATA_W,
    parameter int MEM_DEPTH  = AXI_MEM_DEPTH
) (
    input  logic            ACLK,
    input  logic            ARESET,
    axi4_slave_mem_if.slave bus
);
    localparam int NB  = DATA_WIDTH/8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = $clog2(MEM_DEPTH);

    wstate_e w_st, w_nxt;
    rstate_e r_st, r_nxt;
    logic    wload, wadv, rload, radv;
    logic    w_bad_q, w_beat_bad;

    logic [ADDR_WIDTH-1:0] w_addr, w_nxt_addr, r_addr, r_nxt_addr;
    logic w_last, w_err, w_nxt_last, w_nxt_err;
    logic r_last, r_err, r_nxt_last, r_nxt_err;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_wgen (
        .clk(ACLK), .rst(ARESET), .load(wload), .adv(wadv),
        .start_addr(bus.AWADDR), .len(bus.AWLEN), .size(bus.AWSIZE), .burst(bus.AWBURST),
        .addr(w_addr), .last(w_last), .err(w_err),
        .nxt_addr(w_nxt_addr), .nxt_last(w_nxt_last), .nxt_err(w_nxt_err)
    );

    axi4_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH(MEM_DEPTH)) u_rgen (
        .clk(ACLK), .rst(ARESET), .load(rload), .adv(radv),
        .start_addr(bus.ARADDR), .len(bus.ARLEN), .size(bus.ARSIZE), .burst(bus.ARBURST),
        .addr(r_addr), .last(r_last), .err(r_err),
        .nxt_addr(r_nxt_addr), .nxt_last(r_nxt_last), .nxt_err(r_nxt_err)
    );

    logic unused;
    assign unused = ^{w_nxt_addr, w_nxt_last, w_nxt_err, r_addr, r_last, r_err, w_addr, r_nxt_addr};

    always_comb begin
        w_nxt = w_st;
        wload = 1'b0;
        wadv  = 1'b0;
        case (w_st)
            W_IDLE: if (bus.AWVALID && bus.AWREADY) begin
                w_nxt = W_DATA;
                wload = 1'b1;
            end
            W_DATA: if (bus.WVALID && bus.WREADY) begin
                wadv = 1'b1;
                if (w_last) w_nxt = W_RESP;
            end
            W_RESP: if (bus.BVALID && bus.BREADY) w_nxt = W_IDLE;
            default: w_nxt = W_IDLE;
        endcase
    end

    // The beat counter ends the burst; a disagreeing WLAST only taints BRESP
    assign w_beat_bad = w_err || (bus.WLAST != w_last);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_st        <= W_IDLE;
            bus.AWREADY <= 1'b0;
            bus.WREADY  <= 1'b0;
            bus.BVALID  <= 1'b0;
            bus.BRESP   <= RESP_OKAY;
            w_bad_q     <= 1'b0;
        end else begin
            w_st        <= w_nxt;
            bus.AWREADY <= (w_nxt == W_IDLE);
            bus.WREADY  <= (w_nxt == W_DATA);
            bus.BVALID  <= (w_nxt == W_RESP);
            if (wload)
                w_bad_q <= 1'b0;
            else if (wadv)
                w_bad_q <= w_bad_q | w_beat_bad;
            if (wadv && w_last)
                bus.BRESP <= (w_bad_q || w_beat_bad) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESET && wadv && !w_err)
            for (int b = 0; b < NB; b++)
                if (bus.WSTRB[b])
                    mem[w_addr[OFF +: IW]][8*b +: 8] <= bus.WDATA[8*b +: 8];
    end

    always_comb begin
        r_nxt = r_st;
        rload = 1'b0;
        radv  = 1'b0;
        case (r_st)
            R_IDLE: if (bus.ARVALID && bus.ARREADY) begin
                r_nxt = R_DATA;
                rload = 1'b1;
            end
            R_DATA: if (bus.RVALID && bus.RREADY) begin
                radv = 1'b1;
                if (bus.RLAST) r_nxt = R_IDLE;
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    // Next beat is fetched at the handshake edge; mem writes land on the same
    // edge, so a colliding read sees the old word
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_st        <= R_IDLE;
            bus.ARREADY <= 1'b0;
            bus.RVALID  <= 1'b0;
            bus.RLAST   <= 1'b0;
            bus.RRESP   <= RESP_OKAY;
            bus.RDATA   <= '0;
        end else begin
            r_st        <= r_nxt;
            bus.ARREADY <= (r_nxt == R_IDLE);
            bus.RVALID  <= (r_nxt == R_DATA);
            if (rload || (radv && !bus.RLAST)) begin
                bus.RDATA <= r_nxt_err ? '0 : mem[r_nxt_addr[OFF +: IW]];
                bus.RRESP <= r_nxt_err ? RESP_SLVERR : RESP_OKAY;
                bus.RLAST <= r_nxt_last;
            end else if (radv) begin
                bus.RLAST <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: bursts, strobes, errors, WLAST mismatch,
// RREADY back-pressure and mid-burst reset.
module tb_axi4_slave_mem;
    import axi4_pkg::*;

    localparam int LIM = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [31:0] rdat [16];
    logic [1:0]  rrsp [16];
    logic        rlst [16];
    logic [31:0] expw [4];
    logic [1:0]  expr;
    logic [1:0]  bresp;

    always #5 clk = ~clk;

    axi4_slave_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024)) dut (
        .ACLK(clk), .ARESET(rst), .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu,
                      input logic [31:0] d0, input logic [3:0] st, input int wl, output logic [1:0] resp);
        int n;
        bus.AWADDR = a; bus.AWLEN = 8'(len); bus.AWSIZE = sz; bus.AWBURST = bu; bus.AWVALID = 1'b1;
        n = 0;
        while (!bus.AWREADY && n < LIM) begin @(posedge clk); #1; n++; end
        if (n >= LIM) chk("aw_timeout", 64'(n), 64'(0));
        @(posedge clk); #1;
        bus.AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.WDATA  = d0 + 32'(i);
            bus.WSTRB  = st;
            bus.WLAST  = (wl == -1) ? (i == len) : (i == wl);
            bus.WVALID = 1'b1;
            n = 0;
            while (!bus.WREADY && n < LIM) begin @(posedge clk); #1; n++; end
            if (n >= LIM) chk("w_timeout", 64'(n), 64'(0));
            @(posedge clk); #1;
        end
        bus.WVALID = 1'b0; bus.WLAST = 1'b0;
        chk("wready_in_resp", 64'(bus.WREADY), 64'(0));
        bus.BREADY = 1'b1;
        n = 0;
        while (!bus.BVALID && n < LIM) begin @(posedge clk); #1; n++; end
        if (n >= LIM) chk("b_timeout", 64'(n), 64'(0));
        resp = bus.BRESP;
        @(posedge clk); #1;
        bus.BREADY = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu, input bit tog);
        int n;
        bus.ARADDR = a; bus.ARLEN = 8'(len); bus.ARSIZE = sz; bus.ARBURST = bu; bus.ARVALID = 1'b1;
        n = 0;
        while (!bus.ARREADY && n < LIM) begin @(posedge clk); #1; n++; end
        if (n >= LIM) chk("ar_timeout", 64'(n), 64'(0));
        @(posedge clk); #1;
        bus.ARVALID = 1'b0;
        bus.RREADY  = !tog;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (!bus.RVALID && n < LIM) begin @(posedge clk); #1; n++; end
            if (n >= LIM) chk("r_timeout", 64'(n), 64'(0));
            if (tog) begin @(posedge clk); #1; bus.RREADY = 1'b1; end
            rdat[i] = bus.RDATA; rrsp[i] = bus.RRESP; rlst[i] = bus.RLAST;
            @(posedge clk); #1;
            if (tog) bus.RREADY = 1'b0;
        end
        bus.RREADY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
        bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", 64'(bus.AWREADY), 64'(0));
        chk("rst_arready", 64'(bus.ARREADY), 64'(0));
        chk("rst_wready",  64'(bus.WREADY),  64'(0));
        chk("rst_bvalid",  64'(bus.BVALID),  64'(0));
        chk("rst_rvalid",  64'(bus.RVALID),  64'(0));
        chk("rst_rdata",   64'(bus.RDATA),   64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_awready", 64'(bus.AWREADY), 64'(1));
        chk("post_rst_arready", 64'(bus.ARREADY), 64'(1));

        // INCR write then read back
        wr(32'h100, 3, 3'd2, BURST_INCR, 32'hA0, 4'hF, -1, bresp);
        chk("incr_bresp", 64'(bresp), 64'(RESP_OKAY));
        rd(32'h100, 3, 3'd2, BURST_INCR, 1'b0);
        for (int i = 0; i < 4; i++) chk("incr_rdata", 64'(rdat[i]), 64'(32'hA0 + i));
        chk("incr_rresp", 64'(rrsp[2]), 64'(RESP_OKAY));
        chk("incr_rlast0", 64'(rlst[0]), 64'(0));
        chk("incr_rlast3", 64'(rlst[3]), 64'(1));

        // WRAP read starting mid-container
`ifdef AXI4_SLV_MEM_WRAP_EN
        expw[0] = 32'hA2; expw[1] = 32'hA3; expw[2] = 32'hA0; expw[3] = 32'hA1; expr = RESP_OKAY;
`else
        expw[0] = 32'h0; expw[1] = 32'h0; expw[2] = 32'h0; expw[3] = 32'h0; expr = RESP_SLVERR;
`endif
        rd(32'h108, 3, 3'd2, BURST_WRAP, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_rdata", 64'(rdat[i]), 64'(expw[i]));
            chk("wrap_rresp", 64'(rrsp[i]), 64'(expr));
        end
        chk("wrap_rlast3", 64'(rlst[3]), 64'(1));

        // Partial strobe
        wr(32'h200, 0, 3'd2, BURST_INCR, 32'h12345678, 4'hF, -1, bresp);
        wr(32'h200, 0, 3'd2, BURST_INCR, 32'hFFFFFFFF, 4'h3, -1, bresp);
        rd(32'h200, 0, 3'd2, BURST_INCR, 1'b0);
        chk("strb_rdata", 64'(rdat[0]), 64'(32'h1234FFFF));
        chk("strb_rlast", 64'(rlst[0]), 64'(1));

        // Out-of-range word must not alias onto word 0
        wr(32'h0, 0, 3'd2, BURST_INCR, 32'h5555AAAA, 4'hF, -1, bresp);
        wr(32'h1000, 0, 3'd2, BURST_INCR, 32'hDEADBEEF, 4'hF, -1, bresp);
        chk("oob_bresp", 64'(bresp), 64'(RESP_SLVERR));
        rd(32'h0, 0, 3'd2, BURST_INCR, 1'b0);
        chk("oob_noalias", 64'(rdat[0]), 64'(32'h5555AAAA));
        rd(32'h1000, 0, 3'd2, BURST_INCR, 1'b0);
        chk("oob_rdata", 64'(rdat[0]), 64'(0));
        chk("oob_rresp", 64'(rrsp[0]), 64'(RESP_SLVERR));

        // Oversize beat and reserved burst
        wr(32'h400, 0, 3'd3, BURST_INCR, 32'h1, 4'hF, -1, bresp);
        chk("size_bresp", 64'(bresp), 64'(RESP_SLVERR));
        wr(32'h400, 1, 3'd2, BURST_RSVD, 32'h1, 4'hF, -1, bresp);
        chk("rsvd_bresp", 64'(bresp), 64'(RESP_SLVERR));

        // Early and missing WLAST; data still lands, read back under back-pressure
        wr(32'h300, 3, 3'd2, BURST_INCR, 32'hB0, 4'hF, 1, bresp);
        chk("early_wlast_bresp", 64'(bresp), 64'(RESP_SLVERR));
        wr(32'h310, 1, 3'd2, BURST_INCR, 32'hC0, 4'hF, -2, bresp);
        chk("no_wlast_bresp", 64'(bresp), 64'(RESP_SLVERR));
        rd(32'h300, 3, 3'd2, BURST_INCR, 1'b1);
        for (int i = 0; i < 4; i++) chk("tog_rdata", 64'(rdat[i]), 64'(32'hB0 + i));
        chk("tog_rlast3", 64'(rlst[3]), 64'(1));

        // FIXED burst repeats one word
        rd(32'h104, 2, 3'd2, BURST_FIXED, 1'b0);
        for (int i = 0; i < 3; i++) chk("fixed_rdata", 64'(rdat[i]), 64'(32'hA1));

        // Reset in the middle of a read burst
        bus.ARADDR = 32'h100; bus.ARLEN = 8'd3; bus.ARSIZE = 3'd2; bus.ARBURST = BURST_INCR; bus.ARVALID = 1'b1;
        @(posedge clk); #1;
        bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
        chk("mid_b0", 64'(bus.RDATA), 64'(32'hA0));
        @(posedge clk); #1;
        chk("mid_b1", 64'(bus.RDATA), 64'(32'hA1));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rvalid", 64'(bus.RVALID), 64'(0));
        bus.RREADY = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_arready", 64'(bus.ARREADY), 64'(1));
        rd(32'h104, 1, 3'd2, BURST_INCR, 1'b0);
        chk("after_rst_b0", 64'(rdat[0]), 64'(32'hA1));
        chk("after_rst_b1", 64'(rdat[1]), 64'(32'hA2));
        chk("after_rst_last", 64'(rlst[1]), 64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
